pgm_frame_scanner: RTL and testbench

- Downstream consumer of the PGM image loader. Requests a frame load, waits for the loader to finish, then raster-scans the loaded pixel array by driving row/column addresses.
- Emits a registered pixel stream with frame and line markers and blanking gaps, which feeds the OSD overlay path.
- Single-frame and continuous (frame-after-frame) operation.

---
 rtl/pgm_frame_scanner.sv | 182 ++++++++++++++++++
 tb/tb_pgm_frame_scanner.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_frame_scanner.sv
// Raster scanner behind the PGM loader: one read pulse per frame, row/column
// addressing, then a registered pixel stream with sof/eol/eof markers.
// Ports: clk, rstb (async low), start, continuous -> read, row, column;
//        pix_in (from loader) -> pix_out, pix_valid, sof, eol, eof, busy, frame_cnt.
module pgm_frame_scanner #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 512,
  parameter int BPP       = 12,
  parameter int HBLANK    = 16,
  parameter int VBLANK    = 4,
  parameter int LOAD_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     start,
  input  logic                     continuous,
  output logic                     read,
  output logic [$clog2(HEIGHT):0]  row,
  output logic [$clog2(WIDTH):0]   column,
  input  logic [BPP-1:0]           pix_in,
  output logic [BPP-1:0]           pix_out,
  output logic                     pix_valid,
  output logic                     sof,
  output logic                     eol,
  output logic                     eof,
  output logic                     busy,
  output logic [15:0]              frame_cnt
);

  localparam int RW   = $clog2(HEIGHT) + 1;
  localparam int CLW  = $clog2(WIDTH) + 1;
  localparam int M1   = (LOAD_WAIT > HBLANK) ? LOAD_WAIT : HBLANK;
  localparam int MAXC = (M1 > VBLANK) ? M1 : VBLANK;
  localparam int CNTW = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_ACTIVE, S_HBLANK, S_VBLANK
  } state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CLW-1:0]    col_q, col_d;
  logic              read_q, read_d;
  logic [BPP-1:0]    pix_q, pix_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;
  logic              busy_q, busy_d;
  logic [15:0]       fcnt_q, fcnt_d;

  logic active, col_last, row_last;
  logic line_end, frame_end;

  assign active   = (state_q == S_ACTIVE);
  assign col_last = (col_q == CLW'(WIDTH - 1));
  assign row_last = (row_q == RW'(HEIGHT - 1));

  // Line end and frame end are steps, not states: zero-length blanking
  // falls straight through them in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    line_end  = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_WAIT;
        cnt_d   = CNTW'(LOAD_WAIT - 1);
        col_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ACTIVE;
          row_d   = '0;
          col_d   = '0;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_ACTIVE: begin
        if (col_last) begin
          col_d = '0;
          if (HBLANK > 0) begin
            state_d = S_HBLANK;
            cnt_d   = CNTW'(HBLANK - 1);
          end else begin
            line_end = 1'b1;
          end
        end else begin
          col_d = col_q + CLW'(1);
        end
      end
      S_HBLANK: begin
        if (cnt_q == '0) line_end = 1'b1;
        else cnt_d = cnt_q - CNTW'(1);
      end
      S_VBLANK: begin
        if (cnt_q == '0) frame_end = 1'b1;
        else cnt_d = cnt_q - CNTW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (line_end) begin
      if (!row_last) begin
        row_d   = row_q + RW'(1);
        state_d = S_ACTIVE;
      end else if (VBLANK > 0) begin
        state_d = S_VBLANK;
        cnt_d   = CNTW'(VBLANK - 1);
      end else begin
        frame_end = 1'b1;
      end
    end

    if (frame_end) begin
      row_d   = '0;
      state_d = continuous ? S_LOAD : S_IDLE;
    end
  end

  // Pixel path: address driven this cycle, data and markers out next cycle.
  always_comb begin
    read_d  = (state_d == S_LOAD);
    busy_d  = (state_d != S_IDLE);
    valid_d = active;
    pix_d   = active ? pix_in : pix_q;
    sof_d   = active && (row_q == '0) && (col_q == '0);
    eol_d   = active && col_last;
    eof_d   = eol_d && row_last;
    fcnt_d  = fcnt_q + 16'(eof_d);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      read_q  <= 1'b0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      read_q  <= read_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign read      = read_q;
  assign row       = row_q;
  assign column    = col_q;
  assign pix_out   = pix_q;
  assign pix_valid = valid_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_pgm_frame_scanner.sv
// Bench for pgm_frame_scanner: small frames, loader modelled as row*16+col,
// one DUT with blanking and one with zero blanking.
module tb_pgm_frame_scanner;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int HB  = 2;
  localparam int VB  = 1;
  localparam int LW  = 3;

  typedef struct packed {
    logic [11:0] pix;
    logic        sof;
    logic        eol;
    logic        eof;
  } exp_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  logic        start, continuous, read;
  logic [2:0]  row;
  logic [2:0]  column;
  logic [11:0] pix_in, pix_out;
  logic        pix_valid, sof, eol, eof, busy;
  logic [15:0] frame_cnt;

  logic        start_z, cont_z, read_z;
  logic [2:0]  row_z;
  logic [2:0]  column_z;
  logic [11:0] pix_in_z, pix_out_z;
  logic        valid_z, sof_z, eol_z, eof_z, busy_z;
  logic [15:0] fcnt_z;

  assign pix_in   = {5'b0, row, 4'b0} | {9'b0, column};
  assign pix_in_z = {5'b0, row_z, 4'b0} | {9'b0, column_z};

  pgm_frame_scanner #(
    .WIDTH(W), .HEIGHT(H), .BPP(12),
    .HBLANK(HB), .VBLANK(VB), .LOAD_WAIT(LW)
  ) dut (
    .clk(clk), .rstb(rstb), .start(start), .continuous(continuous),
    .read(read), .row(row), .column(column), .pix_in(pix_in),
    .pix_out(pix_out), .pix_valid(pix_valid), .sof(sof), .eol(eol),
    .eof(eof), .busy(busy), .frame_cnt(frame_cnt)
  );

  pgm_frame_scanner #(
    .WIDTH(W), .HEIGHT(H), .BPP(12),
    .HBLANK(0), .VBLANK(0), .LOAD_WAIT(LW)
  ) dut_z (
    .clk(clk), .rstb(rstb), .start(start_z), .continuous(cont_z),
    .read(read_z), .row(row_z), .column(column_z), .pix_in(pix_in_z),
    .pix_out(pix_out_z), .pix_valid(valid_z), .sof(sof_z), .eol(eol_z),
    .eof(eof_z), .busy(busy_z), .frame_cnt(fcnt_z)
  );

  int tests = 0;
  int fails = 0;
  exp_t sbq[$];
  exp_t sbz[$];

  function automatic void push_frame(input bit z);
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.pix = 12'(r * 16 + c);
        e.sof = (r == 0) && (c == 0);
        e.eol = (c == W - 1);
        e.eof = (r == H - 1) && (c == W - 1);
        if (z) sbz.push_back(e);
        else sbq.push_back(e);
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
  endtask

  // Start is set between edges and sampled at the next posedge; the
  // following negedge is the read cycle (n = 0 in the tasks below).
  task automatic kick();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 0; continuous = 0; start_z = 0; cont_z = 0;
    rstb = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({read, row, column, pix_out, pix_valid, sof, eol, eof, busy,
         frame_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0",
        {read, row, column, pix_out, pix_valid, sof, eol, eof, busy,
         frame_cnt});
    end
    tests++;
    if ({read_z, valid_z, busy_z, fcnt_z} !== '0) begin
      fails++;
      $display("FAIL reset_outputs_z: got %h want 0",
        {read_z, valid_z, busy_z, fcnt_z});
    end
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || pix_valid !== 1'b0 || read !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b valid=%b read=%b want 0 0 0",
        busy, pix_valid, read);
    end
  endtask

  task automatic test_single_frame();
    int n, reads, npix, sof_n, prev;
    bit done;
    exp_t e;
    do_reset();
    sbq.delete();
    push_frame(0);
    continuous = 0;
    kick();
    tests++;
    if (read !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_read: read=%b busy=%b want 1 1", read, busy);
    end
    n = 0; reads = 1; npix = 0; sof_n = -1; prev = -1; done = 0;
    while (n < 80 && !done) begin
      @(negedge clk);
      n++;
      if (read) reads++;
      if (pix_valid) begin
        if (sof) sof_n = n;
        if (npix % W == 0 && npix > 0) begin
          tests++;
          if (n - prev - 1 != HB) begin
            fails++;
            $display("FAIL line_gap: got %0d want %0d", n - prev - 1, HB);
          end
        end
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL extra_pixel: got %h want none", pix_out);
        end else begin
          e = sbq.pop_front();
          if ({pix_out, sof, eol, eof} !== e) begin
            fails++;
            $display("FAIL pixel: got %h want %h",
              {pix_out, sof, eol, eof}, e);
          end
        end
        prev = n;
        npix++;
      end
      if (!busy) done = 1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL single_timeout: busy=%b want 0", busy);
    end
    tests++;
    if (sof_n != LW + 2) begin
      fails++;
      $display("FAIL sof_latency: got %0d want %0d", sof_n, LW + 2);
    end
    tests++;
    if (npix != W * H || sbq.size() != 0) begin
      fails++;
      $display("FAIL pixel_count: got %0d want %0d", npix, W * H);
    end
    tests++;
    if (reads != 1) begin
      fails++;
      $display("FAIL read_count: got %0d want 1", reads);
    end
    tests++;
    if (frame_cnt !== 16'd1) begin
      fails++;
      $display("FAIL frame_cnt_single: got %0d want 1", frame_cnt);
    end
  endtask

  task automatic test_continuous();
    int n, npix, eofs, eof1, r2;
    exp_t e;
    do_reset();
    sbq.delete();
    push_frame(0);
    push_frame(0);
    continuous = 1;
    kick();
    n = 0; npix = 0; eofs = 0; eof1 = -1; r2 = -1;
    while (n < 150 && eofs < 2) begin
      @(negedge clk);
      n++;
      if (read && r2 < 0) r2 = n;
      if (pix_valid) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL extra_pixel_cont: got %h want none", pix_out);
        end else begin
          e = sbq.pop_front();
          if ({pix_out, sof, eol, eof} !== e) begin
            fails++;
            $display("FAIL pixel_cont: got %h want %h",
              {pix_out, sof, eol, eof}, e);
          end
        end
        npix++;
        if (eof) begin
          eofs++;
          if (eofs == 1) begin
            eof1 = n;
            tests++;
            if (frame_cnt !== 16'd1) begin
              fails++;
              $display("FAIL frame_cnt_eof1: got %0d want 1", frame_cnt);
            end
          end
        end
      end
      start = (npix == 6);
    end
    start = 0;
    tests++;
    if (eofs != 2) begin
      fails++;
      $display("FAIL cont_timeout: got %0d eofs want 2", eofs);
    end
    // eof shows one cycle after its address cycle, so read trails it
    // by exactly the blanking.
    tests++;
    if (r2 - eof1 != HB + VB) begin
      fails++;
      $display("FAIL read2_after_eof: got %0d want %0d", r2 - eof1, HB + VB);
    end
    tests++;
    if (r2 != 1 + LW + H * (W + HB) + VB) begin
      fails++;
      $display("FAIL frame_length: got %0d want %0d",
        r2, 1 + LW + H * (W + HB) + VB);
    end
    tests++;
    if (frame_cnt !== 16'd2) begin
      fails++;
      $display("FAIL frame_cnt_cont: got %0d want 2", frame_cnt);
    end
    continuous = 0;
  endtask

  task automatic test_cont_drop();
    int n, npix, eofs, reads, bad;
    bit done;
    exp_t e;
    do_reset();
    sbq.delete();
    push_frame(0);
    push_frame(0);
    continuous = 1;
    kick();
    n = 0; npix = 0; eofs = 0; reads = 1; done = 0;
    while (n < 200 && !done) begin
      @(negedge clk);
      n++;
      if (read) reads++;
      if (pix_valid) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL extra_pixel_drop: got %h want none", pix_out);
        end else begin
          e = sbq.pop_front();
          if ({pix_out, sof, eol, eof} !== e) begin
            fails++;
            $display("FAIL pixel_drop: got %h want %h",
              {pix_out, sof, eol, eof}, e);
          end
        end
        npix++;
        if (eof) eofs++;
      end
      if (reads == 2 && npix >= 14) continuous = 0;
      if (!busy) done = 1;
    end
    tests++;
    if (!done || eofs != 2 || sbq.size() != 0) begin
      fails++;
      $display("FAIL drop_complete: done=%b eofs=%0d left=%0d want 1 2 0",
        done, eofs, sbq.size());
    end
    tests++;
    if (frame_cnt !== 16'd2 || reads != 2) begin
      fails++;
      $display("FAIL drop_counts: cnt=%0d reads=%0d want 2 2",
        frame_cnt, reads);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (read || busy || pix_valid) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL drop_idle: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_zero_blank();
    int n, npix, prev, gaps, eofn;
    exp_t e;
    do_reset();
    sbz.delete();
    push_frame(1);
    cont_z = 1;
    start_z = 1;
    @(posedge clk);
    @(negedge clk);
    start_z = 0;
    n = 0; npix = 0; prev = -1; gaps = 0; eofn = -1;
    while (n < 60 && eofn < 0) begin
      @(negedge clk);
      n++;
      if (valid_z) begin
        if (prev >= 0 && n != prev + 1) gaps++;
        prev = n;
        tests++;
        if (sbz.size() == 0) begin
          fails++;
          $display("FAIL extra_pixel_z: got %h want none", pix_out_z);
        end else begin
          e = sbz.pop_front();
          if ({pix_out_z, sof_z, eol_z, eof_z} !== e) begin
            fails++;
            $display("FAIL pixel_z: got %h want %h",
              {pix_out_z, sof_z, eol_z, eof_z}, e);
          end
        end
        npix++;
        if (eof_z) begin
          eofn = n;
          tests++;
          if (read_z !== 1'b1) begin
            fails++;
            $display("FAIL read_z_at_eof: got %b want 1", read_z);
          end
        end
      end
    end
    tests++;
    if (gaps != 0 || npix != W * H) begin
      fails++;
      $display("FAIL zero_gap: gaps=%0d pix=%0d want 0 %0d",
        gaps, npix, W * H);
    end
    tests++;
    if (eofn != 1 + LW + H * W) begin
      fails++;
      $display("FAIL zero_len: got %0d want %0d", eofn, 1 + LW + H * W);
    end
    cont_z = 0;
  endtask

  task automatic test_async_reset();
    int n, npix, bad;
    do_reset();
    continuous = 1;
    kick();
    n = 0; npix = 0;
    while (n < 40 && npix < 5) begin
      @(negedge clk);
      n++;
      if (pix_valid) npix++;
    end
    tests++;
    if (npix < 5 || busy !== 1'b1) begin
      fails++;
      $display("FAIL async_setup: pix=%0d busy=%b want 5 1", npix, busy);
    end
    #2 rstb = 1'b0;
    #1;
    tests++;
    if ({read, row, column, pix_out, pix_valid, sof, eol, eof, busy,
         frame_cnt} !== '0) begin
      fails++;
      $display("FAIL async_reset: got %h want 0",
        {read, row, column, pix_out, pix_valid, sof, eol, eof, busy,
         frame_cnt});
    end
    continuous = 0;
    @(negedge clk);
    rstb = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || pix_valid || read) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL async_after: got %0d active cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_continuous();
    test_cont_drop();
    test_zero_blank();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
